// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch-stage sequencer between instruction memory and the IF/ID
// boundary. Owns the fetch PC, keeps at most one memory request outstanding,
// buffers returned words in a 2-entry {pc, instr} queue, honours decode stall
// and applies redirects, squashing any in-flight fetch.
//
// Ports:
//   clk, rst        - clock; synchronous active-high reset
//   imem_req/addr   - fetch request and its address (held until acknowledged)
//   imem_ack/rdata  - request accepted; instruction word valid the same cycle
//   redirect_valid  - one-cycle pulse: flush and restart at redirect_pc
//   redirect_pc     - new fetch address (low two bits ignored)
//   stall           - decode cannot accept the head entry this cycle
//   if_valid/instr/pc - head queue entry presented to decode (zero when empty)
module fetch_ctrl #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              stall,
    output logic              if_valid,
    output logic [31:0]       if_instr,
    output logic [ADDR_W-1:0] if_pc
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_FULL, S_SQUASH} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    // Address of the request being squashed; fetch_pc already holds the target.
    logic [ADDR_W-1:0] squash_addr_q, squash_addr_d;
    logic [1:0]        count_q, count_d;
    logic              head_q, head_d;
    logic [ADDR_W-1:0] pc_mem_q [2];
    logic [31:0]       instr_mem_q [2];

    logic              push, pop, pop_ok, flush, wr_idx;
    logic [ADDR_W-1:0] redir_target;

    assign redir_target = redirect_pc & ~ADDR_W'(3);
    assign wr_idx       = head_q ^ count_q[0];

    // NOTE: every signal driven here gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        squash_addr_d = squash_addr_q;
        imem_req      = 1'b0;
        imem_addr     = fetch_pc_q;
        push          = 1'b0;
        flush         = 1'b0;
        pop_ok        = (count_q != 2'd0) && !stall;

        case (state_q)
            S_IDLE: begin
                // Redirects are ignored here: the reset vector wins.
                state_d = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (redirect_valid) begin
                    flush      = 1'b1;
                    fetch_pc_d = redir_target;
                    if (!imem_ack) begin
                        // Request must stay stable until acked; remember it.
                        state_d       = S_SQUASH;
                        squash_addr_d = fetch_pc_q;
                    end
                end else if (imem_ack) begin
                    push       = 1'b1;
                    fetch_pc_d = fetch_pc_q + ADDR_W'(4);
                end
            end
            S_FULL: begin
                if (redirect_valid) begin
                    flush      = 1'b1;
                    fetch_pc_d = redir_target;
                    state_d    = S_FETCH;
                end else if (pop_ok) begin
                    state_d = S_FETCH;
                end
            end
            S_SQUASH: begin
                imem_req  = 1'b1;
                imem_addr = squash_addr_q;
                if (redirect_valid) begin
                    flush      = 1'b1;
                    fetch_pc_d = redir_target;
                end
                // Stale word is dropped; the new address goes out next cycle.
                if (imem_ack) state_d = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase

        // A flush wipes the queue, so the head is not consumed that cycle.
        pop     = pop_ok && !flush;
        count_d = flush ? 2'd0 : count_q + 2'(push) - 2'(pop);
        head_d  = head_q ^ pop;

        if (state_q == S_FETCH && push && count_d == 2'd2) state_d = S_FULL;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            fetch_pc_q    <= RESET_PC;
            squash_addr_q <= RESET_PC;
            count_q       <= 2'd0;
            head_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            squash_addr_q <= squash_addr_d;
            count_q       <= count_d;
            head_q        <= head_d;
        end
    end

    // NOTE: queue storage has no reset; entries are only observed through
    // count_q, which is reset, so clearing the data would be wasted logic.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[wr_idx]    <= fetch_pc_q;
            instr_mem_q[wr_idx] <= imem_rdata;
        end
    end

    assign if_valid = (count_q != 2'd0);
    assign if_pc    = if_valid ? pc_mem_q[head_q]    : '0;
    assign if_instr = if_valid ? instr_mem_q[head_q] : '0;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Testbench for fetch_ctrl: directed scenarios with literal expectations plus
// a queue-based reference model compared against the DUT on every negedge.
module tb_fetch_ctrl;

    localparam int          AW   = 32;
    localparam logic [31:0] RPC  = 32'h0;

    logic          clk = 1'b0;
    logic          rst;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack;
    logic [31:0]   imem_rdata;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic          stall;
    logic          if_valid;
    logic [31:0]   if_instr;
    logic [AW-1:0] if_pc;

    int n_tests = 0;
    int n_fail  = 0;

    fetch_ctrl #(.ADDR_W(AW), .RESET_PC(RPC)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .stall(stall),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc)
    );

    always #5 clk = ~clk;

    // Memory returns a word derived from its address, so misplaced data shows.
    always @* imem_rdata = imem_addr ^ 32'hDEAD_0000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
    ent_t        mq[$];
    logic [31:0] m_pc      = RPC;
    logic [31:0] m_daddr   = RPC;
    bit          m_boot    = 1'b1;  // the idle cycle after reset release
    bit          m_discard = 1'b0;  // an outstanding request will be dropped

    always @(negedge clk) begin
        logic        e_req, e_valid, ack_eff;
        logic [31:0] e_addr, e_pc, e_instr;
        e_req   = !m_boot && (m_discard || mq.size() < 2);
        e_addr  = m_discard ? m_daddr : m_pc;
        e_valid = mq.size() != 0;
        e_pc    = e_valid ? mq[0].pc    : 32'h0;
        e_instr = e_valid ? mq[0].instr : 32'h0;
        check("mdl_req",   32'(imem_req),  32'(e_req));
        check("mdl_addr",  imem_addr,      e_addr);
        check("mdl_valid", 32'(if_valid),  32'(e_valid));
        check("mdl_pc",    if_pc,          e_pc);
        check("mdl_instr", if_instr,       e_instr);

        if (rst) begin
            mq.delete();
            m_pc = RPC; m_boot = 1'b1; m_discard = 1'b0;
        end else if (m_boot) begin
            m_boot = 1'b0;
        end else begin
            ack_eff = e_req && imem_ack;
            if (redirect_valid) begin
                mq.delete();
                if (e_req && !ack_eff) begin
                    if (!m_discard) m_daddr = m_pc;
                    m_discard = 1'b1;
                end else begin
                    m_discard = 1'b0;
                end
                m_pc = {redirect_pc[31:2], 2'b00};
            end else begin
                if (mq.size() > 0 && !stall) void'(mq.pop_front());
                if (ack_eff) begin
                    if (m_discard) m_discard = 1'b0;
                    else begin
                        mq.push_back('{m_pc, imem_rdata});
                        m_pc = m_pc + 32'd4;
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic st, input logic ak);
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        stall = st; imem_ack = ak;
        cyc(); cyc();
        check("rst_req",   32'(imem_req), 32'd0);
        check("rst_addr",  imem_addr,     RPC);
        check("rst_valid", 32'(if_valid), 32'd0);
        check("rst_pc",    if_pc,         32'd0);
        check("rst_instr", if_instr,      32'd0);
        rst = 1'b0;
    endtask

    initial begin
        logic [47:0] stall_pat;
        logic [47:0] ack_pat;
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; stall = 1'b0; imem_ack = 1'b0;

        // 1: streaming, zero-wait memory
        do_reset(1'b0, 1'b1);
        cyc();
        check("s1_req",  32'(imem_req), 32'd1);
        check("s1_a0",   imem_addr,     32'h0);
        check("s1_nv",   32'(if_valid), 32'd0);
        cyc();
        check("s1_v",    32'(if_valid), 32'd1);
        check("s1_pc0",  if_pc,         32'h0);
        check("s1_i0",   if_instr,      32'hDEAD_0000);
        check("s1_a4",   imem_addr,     32'h4);
        cyc();
        check("s1_pc4",  if_pc,         32'h4);
        check("s1_i4",   if_instr,      32'hDEAD_0004);
        check("s1_a8",   imem_addr,     32'h8);
        repeat (3) cyc();

        // 2: decode stalled fills the queue, release pops and refetches
        do_reset(1'b1, 1'b1);
        cyc(); cyc(); cyc();
        check("s2_req0", 32'(imem_req), 32'd0);
        check("s2_pc0",  if_pc,         32'h0);
        cyc();
        check("s2_hold", 32'(imem_req), 32'd0);
        stall = 1'b0;
        cyc();
        check("s2_pc4",  if_pc,         32'h4);
        check("s2_req1", 32'(imem_req), 32'd1);
        check("s2_a8",   imem_addr,     32'h8);
        repeat (2) cyc();

        // 3: ack arrives on the fourth request cycle
        do_reset(1'b0, 1'b0);
        cyc();
        for (int i = 0; i < 4; i++) begin
            check("s3_req",   32'(imem_req), 32'd1);
            check("s3_addr",  imem_addr,     32'h0);
            check("s3_nv",    32'(if_valid), 32'd0);
            if (i == 3) imem_ack = 1'b1;
            cyc();
        end
        imem_ack = 1'b0;
        check("s3_v",     32'(if_valid), 32'd1);
        check("s3_pc",    if_pc,         32'h0);
        check("s3_a4",    imem_addr,     32'h4);
        cyc();
        check("s3_single", 32'(if_valid), 32'd0);

        // 4: redirect with a request to 0x8 outstanding
        do_reset(1'b0, 1'b1);
        cyc(); cyc(); cyc();
        check("s4_a8",   imem_addr, 32'h8);
        imem_ack = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h103;
        cyc();
        redirect_valid = 1'b0;
        check("s4_flush", 32'(if_valid), 32'd0);
        check("s4_stale", imem_addr,     32'h8);
        check("s4_req",   32'(imem_req), 32'd1);
        cyc();
        check("s4_stale2", imem_addr,    32'h8);
        imem_ack = 1'b1;
        cyc();
        check("s4_a100", imem_addr,     32'h100);
        check("s4_nv",   32'(if_valid), 32'd0);
        cyc();
        check("s4_pc",   if_pc,         32'h100);
        check("s4_i",    if_instr,      32'hDEAD_0100);
        cyc();

        // 5: redirect coincident with ack and pop
        do_reset(1'b0, 1'b1);
        cyc(); cyc(); cyc();
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        cyc();
        redirect_valid = 1'b0;
        check("s5_nv",   32'(if_valid), 32'd0);
        check("s5_addr", imem_addr,     32'h200);
        cyc();
        check("s5_pc",   if_pc,         32'h200);

        // 6: reset with a request outstanding and an entry queued
        do_reset(1'b1, 1'b1);
        cyc(); cyc();
        imem_ack = 1'b0;
        cyc();
        check("s6_pre",  32'(if_valid), 32'd1);
        check("s6_out",  imem_addr,     32'h4);
        rst = 1'b1; imem_ack = 1'b1;
        cyc();
        check("s6_req",  32'(imem_req), 32'd0);
        check("s6_addr", imem_addr,     RPC);
        check("s6_v",    32'(if_valid), 32'd0);
        check("s6_pc",   if_pc,         32'd0);
        rst = 1'b0;
        cyc();
        check("s6_idle", 32'(if_valid), 32'd0);
        cyc();
        check("s6_restart", if_pc,      32'h0);
        stall = 1'b0;
        repeat (2) cyc();

        // 7: PC wraps modulo 2^ADDR_W
        do_reset(1'b0, 1'b1);
        cyc(); cyc();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
        cyc();
        redirect_valid = 1'b0;
        check("s7_top",  imem_addr, 32'hFFFF_FFFC);
        cyc();
        check("s7_wrap", imem_addr, 32'h0);
        check("s7_pc",   if_pc,     32'hFFFF_FFFC);

        // 8: mixed stall/ack/redirect traffic checked by the model
        do_reset(1'b0, 1'b1);
        stall_pat = 48'h3C0F_0336_C1E0;
        ack_pat   = 48'hF7BD_6EF3_9DFB;
        for (int i = 0; i < 48; i++) begin
            stall          = stall_pat[i];
            imem_ack       = ack_pat[i];
            redirect_valid = (i % 13 == 7);
            redirect_pc    = 32'h400 + 32'(i * 8) + 32'd2;
            cyc();
        end
        redirect_valid = 1'b0; stall = 1'b0; imem_ack = 1'b1;
        repeat (3) cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
